// File: rtl/bna_pkg.sv
// Shared types and defaults for the MAC-column control blocks.
// Holds the weight_load_ctrl state encoding and the stall counter width.
package bna_pkg;

    localparam int BNA_ARRAY_ROWS   = 16;
    localparam int BNA_WEIGHT_WIDTH = 8;
    localparam int WLC_STALL_CNT_W  = 32;

    typedef enum logic [2:0] {
        WLC_IDLE    = 3'd0,
        WLC_LOAD    = 3'd1,
        WLC_COMMIT  = 3'd2,
        WLC_COMPUTE = 3'd3,
        WLC_DRAIN   = 3'd4,
        WLC_DONE    = 3'd5
    } wlc_state_t;

endpackage

// File: rtl/weight_load_ctrl.sv
// Weight load / compute / drain sequencer for one column of mac_unit_noadder PEs.
// Optional LOAD stall counter enabled by defining WLC_STALL_CNT_EN.
module weight_load_ctrl
    import bna_pkg::*;
#(
    parameter int ARRAY_ROWS        = BNA_ARRAY_ROWS,
    parameter int WEIGHT_WIDTH      = BNA_WEIGHT_WIDTH,
    parameter int COMPUTE_LEN_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [COMPUTE_LEN_WIDTH-1:0]  compute_len_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          w_fifo_valid_i,
    input  logic [2*WEIGHT_WIDTH-1:0]     w_fifo_data_i,
    output logic                          w_fifo_ready_o,
    output logic                          prepare_weight_o,
    output logic                          set_weight_o,
    output logic [WEIGHT_WIDTH-1:0]       load_weight_data_0_o,
    output logic [WEIGHT_WIDTH-1:0]       load_weight_data_1_o,
    output logic                          act_rd_en_o,
    output logic [WLC_STALL_CNT_W-1:0]    stall_cycles_o
);

    localparam int CNT_W = $clog2(ARRAY_ROWS + 2);
    // The shared phase counter must also hold the full compute length.
    localparam int PH_W  = (COMPUTE_LEN_WIDTH > CNT_W) ? COMPUTE_LEN_WIDTH : CNT_W;

    localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);
    localparam logic [PH_W-1:0] LOAD_LAST  = PH_W'(ARRAY_ROWS - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(ARRAY_ROWS);

    wlc_state_t                   state_q, state_d;
    logic [PH_W-1:0]              cnt_q, cnt_d;
    logic [COMPUTE_LEN_WIDTH-1:0] len_q, len_d;
    logic                         start_acc;

    assign load_weight_data_0_o = w_fifo_data_i[WEIGHT_WIDTH-1:0];
    assign load_weight_data_1_o = w_fifo_data_i[2*WEIGHT_WIDTH-1:WEIGHT_WIDTH];
    assign start_acc            = (state_q == WLC_IDLE) && start_i;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        len_d            = len_q;
        busy_o           = (state_q != WLC_IDLE);
        done_o           = 1'b0;
        w_fifo_ready_o   = 1'b0;
        prepare_weight_o = 1'b0;
        set_weight_o     = 1'b0;
        act_rd_en_o      = 1'b0;
        unique case (state_q)
            WLC_IDLE: begin
                if (start_i) begin
                    len_d   = compute_len_i;
                    cnt_d   = '0;
                    state_d = WLC_LOAD;
                end
            end
            WLC_LOAD: begin
                w_fifo_ready_o   = 1'b1;
                prepare_weight_o = w_fifo_valid_i;
                if (w_fifo_valid_i) begin
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = '0;
                        state_d = WLC_COMMIT;
                    end else begin
                        cnt_d = cnt_q + PH_ONE;
                    end
                end
            end
            WLC_COMMIT: begin
                set_weight_o = 1'b1;
                if (len_q == '0) begin
                    cnt_d   = '0;
                    state_d = WLC_DRAIN;
                end else begin
                    cnt_d   = PH_W'(len_q);
                    state_d = WLC_COMPUTE;
                end
            end
            WLC_COMPUTE: begin
                act_rd_en_o = 1'b1;
                if (cnt_q == PH_ONE) begin
                    cnt_d   = '0;
                    state_d = WLC_DRAIN;
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end
            // Activations ripple through ARRAY_ROWS PEs plus one multiply cycle.
            WLC_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = WLC_DONE;
                end else begin
                    cnt_d = cnt_q + PH_ONE;
                end
            end
            WLC_DONE: begin
                done_o  = 1'b1;
                state_d = WLC_IDLE;
            end
            default: state_d = WLC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WLC_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

`ifdef WLC_STALL_CNT_EN
    logic [WLC_STALL_CNT_W-1:0] stall_q, stall_d;

    function automatic logic [WLC_STALL_CNT_W-1:0] sat_inc(input logic [WLC_STALL_CNT_W-1:0] v);
        return (&v) ? v : v + WLC_STALL_CNT_W'(1);
    endfunction

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if ((state_q == WLC_LOAD) && !w_fifo_valid_i) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign stall_cycles_o   = '0;
`endif

endmodule
